// File: rtl/tx_jogada_serial_if.sv
// Bundle of the move/result inputs and UART status outputs that pass between
// the game control unit (master) and the serial record transmitter (slave).
interface tx_jogada_serial_if;
  logic       partida;
  logic [3:0] macro;
  logic [3:0] micro;
  logic [1:0] jogador;
  logic [1:0] resultado;
  logic       saida_serial;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  modport master (
    output partida, macro, micro, jogador, resultado,
    input  saida_serial, ocupado, pronto, db_estado
  );

  modport slave (
    input  partida, macro, micro, jogador, resultado,
    output saida_serial, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/tx_jogada_serial.sv
// Serial record transmitter for the game datapath.
// On a start request it latches the last move and the game result, then sends a
// 5-character ASCII record (macro, micro, player, result, LF) over a UART line,
// LSB first. Default framing is 8N1; defining PARIDADE_EN inserts an even parity
// bit between D7 and the stop bit (8E1).
module tx_jogada_serial #(
  parameter int CICLOS_POR_BIT = 434,
  parameter int LARGURA_CNT    = 16
) (
  input  logic             clock,
  input  logic             reset,
  tx_jogada_serial_if.slave bus
);

`ifdef PARIDADE_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    PREPARA   = 3'd1,
    TRANSMITE = 3'd2,
    PROXIMO   = 3'd3,
    FINAL     = 3'd4
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [3:0]             macro_r, micro_r;
  logic [1:0]             jogador_r, resultado_r;
  logic [2:0]             indice;
  logic [LARGURA_CNT-1:0] cnt_baud;
  logic [3:0]             cnt_bit;
  logic [NBITS-1:0]       quadro;
  logic [NBITS-1:0]       quadro_novo;
  logic [7:0]             caractere;
  logic                   saida_r, ocupado_r, pronto_r;
  logic                   fim_bit, ultimo_bit;

  // Addresses above 9 have no decimal digit, so they are shown as '?'.
  function automatic logic [7:0] ascii_endereco(input logic [3:0] a);
    if (a > 4'd9) return 8'h3F;
    else          return 8'h30 + {4'h0, a};
  endfunction

  assign fim_bit    = (cnt_baud == LARGURA_CNT'(CICLOS_POR_BIT - 1));
  assign ultimo_bit = (cnt_bit == 4'(NBITS - 1));

  // Select the record character addressed by the current index.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    caractere = 8'h0A;
    case (indice)
      3'd0: caractere = ascii_endereco(macro_r);
      3'd1: caractere = ascii_endereco(micro_r);
      3'd2: begin
        case (jogador_r)
          2'b01:   caractere = 8'h58;
          2'b10:   caractere = 8'h4F;
          default: caractere = 8'h2D;
        endcase
      end
      3'd3:    caractere = 8'h30 + {6'h0, resultado_r};
      default: caractere = 8'h0A;
    endcase
  end

  // Build the UART frame, start bit in bit 0 so it leaves the shifter first.
  always_comb begin
`ifdef PARIDADE_EN
    quadro_novo = {1'b1, ^caractere, caractere, 1'b0};
`else
    quadro_novo = {1'b1, caractere, 1'b0};
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  // Next-state decode; unused codes fall back to INICIAL.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:   if (bus.partida) estado_d = PREPARA;
      PREPARA:   estado_d = TRANSMITE;
      TRANSMITE: if (fim_bit && ultimo_bit) estado_d = PROXIMO;
      PROXIMO:   estado_d = (indice == 3'd4) ? FINAL : PREPARA;
      FINAL:     estado_d = INICIAL;
      default:   estado_d = INICIAL;
    endcase
  end

  // Datapath: input latch, character index, baud/bit counters, shifter and
  // registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      macro_r     <= '0;
      micro_r     <= '0;
      jogador_r   <= '0;
      resultado_r <= '0;
      indice      <= '0;
      cnt_baud    <= '0;
      cnt_bit     <= '0;
      quadro      <= '1;
      saida_r     <= 1'b1;
      ocupado_r   <= 1'b0;
      pronto_r    <= 1'b0;
    end else begin
      // Line only follows the shifter while transmitting; it idles high otherwise.
      saida_r   <= (estado_q == TRANSMITE) ? quadro[0] : 1'b1;
      ocupado_r <= (estado_d != INICIAL) && (estado_d != FINAL);
      pronto_r  <= (estado_q == FINAL);

      case (estado_q)
        INICIAL: begin
          if (bus.partida) begin
            macro_r     <= bus.macro;
            micro_r     <= bus.micro;
            jogador_r   <= bus.jogador;
            resultado_r <= bus.resultado;
            indice      <= 3'd0;
          end
        end
        PREPARA: begin
          quadro   <= quadro_novo;
          cnt_baud <= '0;
          cnt_bit  <= '0;
        end
        TRANSMITE: begin
          if (fim_bit) begin
            cnt_baud <= '0;
            cnt_bit  <= cnt_bit + 4'd1;
            quadro   <= {1'b1, quadro[NBITS-1:1]};
          end else begin
            cnt_baud <= cnt_baud + LARGURA_CNT'(1);
          end
        end
        PROXIMO: begin
          if (indice != 3'd4) indice <= indice + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.saida_serial = saida_r;
  assign bus.ocupado      = ocupado_r;
  assign bus.pronto       = pronto_r;
  assign bus.db_estado    = estado_q;

endmodule
